// File: rtl/uart_pkg.sv
// Shared UART constants and the tx feeder state encoding.
// Pure declarations: no latency or backpressure of its own.
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int DEFAULT_FIFO_DEPTH  = 16;
    localparam int DEFAULT_ACK_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } feed_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with registered occupancy; a push is visible in count one edge later.
// Backpressure: a push while full is discarded and latches the sticky overflow flag.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       push_data_i,
    input  logic                    pop_i,
    output logic [DATA_W-1:0]       head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_ok, pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign head_o     = mem_q[rd_ptr_q];

    // Acceptance uses the registered full flag, so a same-cycle pop cannot rescue a write.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_i && full_o) begin
            overflow_d = 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and sequences start/ready handshakes into the UART transmitter.
// Write-to-start latency 2 cycles; writes while full are dropped and flagged; unacked starts time out.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_FIFO_DEPTH,
    parameter int DATA_W      = UART_DATA_W,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_en,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    ack_err,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    tx_start,
    input  logic                    tx_ready
);

    localparam int              TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(ACK_TIMEOUT - 1);

    feed_state_e       state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              ack_err_q, ack_err_d;
    logic              pop;
    logic [DATA_W-1:0] head;

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wr_en),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow)
    );

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign ack_err  = ack_err_q;

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        ack_err_d  = ack_err_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                tx_start_d = 1'b0;
                if (!empty && tx_ready) begin
                    tx_data_d  = head;
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (!tx_ready) begin
                    tx_start_d = 1'b0;
                    state_d    = BUSY;
                end else if (tmo_q == TMO_LAST) begin
                    // Byte is abandoned rather than retried so a dead transmitter cannot stall the queue.
                    tx_start_d = 1'b0;
                    ack_err_d  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            BUSY: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            ack_err_q  <= ack_err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed and randomized bench for uart_tx_feeder against a queue-based reference model.
module tb_uart_tx_feeder;

    localparam int DEPTH       = 16;
    localparam int DATA_W      = 8;
    localparam int ACK_TIMEOUT = 64;

    logic                   clk      = 1'b0;
    logic                   rst      = 1'b1;
    logic [DATA_W-1:0]      wr_data  = '0;
    logic                   wr_en    = 1'b0;
    logic                   tx_ready = 1'b1;
    logic                   full, empty, overflow, ack_err, tx_start;
    logic [$clog2(DEPTH):0] count;
    logic [DATA_W-1:0]      tx_data;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ack_err  (ack_err),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of accepted bytes plus the sticky flags.
    logic [7:0] model_q[$];
    logic [7:0] rx_q[$];
    logic       exp_ovf, exp_ack, ack_pending;
    logic       prev_start;
    logic [7:0] held_data;
    int         run, cyc, mode, busy_left, busy_len;
    bit         busy_rand;
    int         start_cnt, start_cyc, rise_cyc, pulse_len, last_pulse_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_ovf     = 1'b0;
        exp_ack     = 1'b0;
        ack_pending = 1'b0;
        prev_start  = 1'b0;
        held_data   = 8'h00;
        run         = 0;
        busy_left   = 0;
        pulse_len   = 0;
    endtask

    // Advance one clock, update the model from what the edge committed, check, then play transmitter.
    task automatic tick();
        logic       w;
        logic [7:0] wd;
        int         pre;
        w   = wr_en;
        wd  = wr_data;
        pre = model_q.size();
        @(posedge clk);
        #1;
        cyc++;
        exp_ack     = exp_ack | ack_pending;
        ack_pending = 1'b0;
        if (tx_start && !prev_start) begin
            start_cnt++;
            start_cyc = cyc;
            pulse_len = 1;
            check("pop_nonempty", (model_q.size() != 0), 1);
            if (model_q.size() != 0) begin
                check("tx_data_head", tx_data, model_q[0]);
                held_data = model_q.pop_front();
            end
        end else begin
            check("tx_data_stable", tx_data, held_data);
            if (tx_start) pulse_len++;
            else if (prev_start) last_pulse_len = pulse_len;
        end
        if (w) begin
            if (pre == DEPTH) exp_ovf = 1'b1;
            else model_q.push_back(wd);
        end
        prev_start = tx_start;
        check("count", count, model_q.size());
        check("empty", empty, (model_q.size() == 0));
        check("full", full, (model_q.size() == DEPTH));
        check("overflow", overflow, exp_ovf);
        check("ack_err", ack_err, exp_ack);
        if (mode == 0) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_ready = 1'b1;
                    rise_cyc = cyc;
                end
            end else if (tx_ready && tx_start) begin
                rx_q.push_back(tx_data);
                tx_ready  = 1'b0;
                busy_left = busy_rand ? int'($urandom_range(1, 8)) : busy_len;
            end
        end
        if (tx_start && tx_ready) begin
            run++;
            if (run == ACK_TIMEOUT) begin
                ack_pending = 1'b1;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("arst_count", count, 0);
        check("arst_tx_start", tx_start, 0);
        check("arst_empty", empty, 1);
        model_reset();
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int wcyc, base;
        cyc = 0; mode = 0; busy_len = 5; busy_rand = 0;
        start_cnt = 0; start_cyc = 0; rise_cyc = 0; last_pulse_len = 0;
        model_reset();

        // Reset values
        #12;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        rst = 1'b0;

        // 1: single byte, start two cycles after the write
        wcyc = cyc;
        write_byte(8'h4B);
        for (int i = 0; i < 10 && start_cnt < 1; i++) tick();
        check("t1_starts", start_cnt, 1);
        check("t1_latency", start_cyc - wcyc, 2);
        check("t1_tx_data", tx_data, 8'h4B);
        tick();
        check("t1_start_fall", tx_start, 0);
        repeat (10) tick();
        check("t1_count", count, 0);
        check("t1_empty", empty, 1);

        // 2: back-to-back bytes through a 40-cycle busy transmitter
        busy_len = 40;
        rx_q.delete();
        base = start_cnt;
        write_byte(8'h4B);
        write_byte(8'h48);
        for (int i = 0; i < 100 && start_cnt < base + 2; i++) tick();
        check("t2_starts", start_cnt - base, 2);
        check("t2_restart_lat", start_cyc - rise_cyc, 2);
        repeat (60) tick();
        check("t2_starts_total", start_cnt - base, 2);
        check("t2_rx_n", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("t2_rx0", rx_q[0], 8'h4B);
            check("t2_rx1", rx_q[1], 8'h48);
        end

        // 3: fill to full, overflow on the 17th, drain in order
        mode = 2; tx_ready = 1'b0; busy_len = 3;
        rx_q.delete();
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        check("t3_full", full, 1);
        check("t3_no_ovf", overflow, 0);
        write_byte(8'h10);
        check("t3_ovf", overflow, 1);
        check("t3_count", count, 16);
        mode = 0; tx_ready = 1'b1;
        repeat (200) tick();
        check("t3_rx_n", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) check("t3_rx_order", rx_q[i], 8'(i));

        // 4: write at full on the pop cycle is still dropped
        do_reset();
        mode = 2; tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'(8'h20 + i));
        check("t4_full", full, 1);
        check("t4_no_ovf", overflow, 0);
        rx_q.delete();
        mode = 0; tx_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        check("t4_count", count, 15);
        check("t4_ovf", overflow, 1);
        check("t4_start", tx_start, 1);
        repeat (150) tick();
        check("t4_rx_n", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++) check("t4_rx_order", rx_q[i], 8'(8'h20 + i));

        // 5: ack timeout with tx_ready stuck high
        mode = 1; tx_ready = 1'b1;
        last_pulse_len = 0;
        write_byte(8'h55);
        repeat (80) tick();
        check("t5_pulse_len", last_pulse_len, ACK_TIMEOUT);
        check("t5_ack_err", ack_err, 1);
        check("t5_count", count, 0);

        // 6: reset while BUSY with three bytes queued
        mode = 0; busy_len = 30; tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) write_byte(8'(8'hB0 + i));
        repeat (3) tick();
        check("t6_pre_count", count, 3);
        do_reset();
        check("t6_ack_clr", ack_err, 0);
        base = start_cnt;
        repeat (10) tick();
        check("t6_no_start", start_cnt, base);
        rx_q.delete();
        write_byte(8'hC3);
        repeat (5) tick();
        check("t6_new_start", start_cnt - base, 1);
        check("t6_new_data", tx_data, 8'hC3);
        repeat (40) tick();

        // Randomized traffic with random transmitter busy times
        do_reset();
        busy_rand = 1;
        for (int i = 0; i < 600; i++) begin
            wr_en   = ($urandom_range(0, 9) < 4);
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        repeat (300) tick();
        check("rand_drained", model_q.size(), 0);
        check("rand_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte buffer and start-handshake sequencer that sits directly upstream of the UART transmitter. It accepts bytes from a producer through a write strobe and stores them in a circular FIFO. It drains the FIFO one byte at a time into the transmitter's parallel data/start/ready interface. It keeps the transmitter busy back-to-back and flags lost bytes, so producers no longer hand-time start pulses.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
DATA_W, 8, byte width; matches transmitter data input.
ACK_TIMEOUT, 64, cycles to wait in START for tx_ready to fall before abandoning the byte.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset; clears all state immediately.
wr_data  in  DATA_W  byte to enqueue.
wr_en  in  1  enqueue strobe, one byte per cycle high.
full  out  1  FIFO holds DEPTH bytes.
empty  out  1  FIFO holds 0 bytes.
count  out  $clog2(DEPTH)+1  current occupancy.
overflow  out  1  sticky: write attempted while full.
ack_err  out  1  sticky: transmitter failed to acknowledge within ACK_TIMEOUT.
tx_data  out  DATA_W  byte presented to transmitter; stable from tx_start rise until ack.
tx_start  out  1  start request to transmitter.
tx_ready  in  1  transmitter idle (high) / busy (low).

Behaviour:
- Reset values: count=0, empty=1, full=0, overflow=0, ack_err=0, tx_data=0, tx_start=0, FSM=IDLE, pointers=0. A reset mid-frame flushes the FIFO and drops tx_start asynchronously. The transmitter's own reset governs the line.
- FIFO:
  - Write pointer and read pointer wrap modulo DEPTH.
  - full and empty derive from registered count.
  - A write with wr_en=1 and full=0 stores the byte at the next edge and sets count+1.
  - A write with wr_en=1 and full=1 discards the byte and sets overflow. This holds even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves count unchanged.
  - A pop while empty never occurs; the FSM guards it.
- FSM states IDLE, START, BUSY:
  - IDLE: if count!=0 and tx_ready=1, register tx_data<=head byte, advance the read pointer, set tx_start<=1, clear the timeout counter, and go to START. Otherwise hold with tx_start=0.
  - START: hold tx_start=1 and tx_data stable.
    - If tx_ready samples 0, set tx_start<=0 and go to BUSY.
    - Else if the timeout counter reaches ACK_TIMEOUT-1, set tx_start<=0, set ack_err, and go to IDLE. The byte is dropped, not retried.
    - Else increment the counter.
  - BUSY: wait for tx_ready=1, then go to IDLE. There is no timeout in BUSY.
- Latency:
  - A write accepted at the edge ending cycle N into an empty FIFO, with the FSM idle and tx_ready=1, gives tx_start=1 in cycle N+2.
  - If tx_ready rises in cycle M while in BUSY and the FIFO is non-empty, the next tx_start=1 appears in cycle M+2.
- tx_data changes only on the IDLE->START transition.
- Sticky flags clear only on rst.
- count width holds the value DEPTH without wrap.

Decomposition:
- Package uart_pkg:
  - feeder state enum (IDLE, START, BUSY)
  - UART_DATA_W=8 constant, shared with the transmitter and receiver
  - DEFAULT_FIFO_DEPTH constant
- Sub-module uart_byte_fifo:
  - interface: storage, pointers, count, full/empty/overflow, push, pop
  - also reusable downstream of the receiver
- uart_tx_feeder keeps only the FSM, the timeout counter and the output registers.

Test Plan:
1. Reset then single byte: rst high 10 ns, low. Write 8'h4B with tx_ready=1 -> tx_start high 2 cycles after write and tx_data=8'h4B. Bench model drops ready 1 cycle after start -> tx_start falls next cycle. count returns to 0 and empty=1.
2. Back-to-back: write 8'h4B, 8'h48 on consecutive cycles. Transmitter model busy 40 cycles each -> exactly two start pulses. Data order 4B then 48. Second tx_start rises 2 cycles after ready returns high. The loopback receiver captures 4B, 48.
3. Full/overflow: with tx_ready held low, write 17 bytes 8'h00..8'h10 (DEPTH=16) -> full=1 after the 16th, overflow=1 after the 17th. Release ready -> 8'h00..8'h0F emitted in order; 8'h10 never appears.
4. Simultaneous write and pop at full: full FIFO, ready rises, write 8'hAA on the pop cycle -> byte dropped, overflow set, count goes 16->15.
5. Ack timeout: tx_ready stuck high, write 8'h55 -> tx_start high exactly ACK_TIMEOUT cycles (64), then low, ack_err=1, count=0.
6. Reset mid-operation: assert rst while in BUSY with 3 bytes queued -> tx_start=0 and count=0 immediately without a clock edge. After release, no start pulse occurs until a new write.
